int_ctrl: RTL and testbench

//   Interrupt controller that sits between the interrupt sources and the control unit (uc).

---
 rtl/int_ctrl.sv | 117 +++++++++++
 tb/tb_int_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latches source events, masks and arbitrates them by fixed priority
// (lowest index wins) and runs the irq/ack/done handshake with the control unit.
module int_ctrl #(
  parameter int unsigned     N_SRC    = 4,
  parameter int unsigned     PC_W     = 10,
  parameter logic [PC_W-1:0] VEC_BASE = 10'h3C0,
  parameter logic [PC_W-1:0] VEC_STEP = 10'd16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_in,
  input  logic             int_en,
  input  logic             we_mask,
  input  logic [N_SRC-1:0] mask_in,
  input  logic             int_ack,
  input  logic             int_done,
  input  logic             clr_lost,
  output logic             irq,
  output logic [PC_W-1:0]  vector,
  output logic             in_service,
  output logic [2:0]       active_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] lost
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] src_q, src_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] lost_q, lost_d;
  logic [2:0]       active_id_q, active_id_d;
  logic [PC_W-1:0]  vector_q, vector_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] req;
  logic             ack_fire;
  logic [2:0]       winner;

  assign rise     = src_in & ~src_q;
  assign ack_fire = (state_q == StReq) && int_ack;
  assign req      = pending_q & mask_q;

  // Walk downwards so the lowest requesting index is the last one written.
  always_comb begin
    winner = 3'd0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (req[i]) winner = 3'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N_SRC); i++) begin
      clr[i] = ack_fire && (active_id_q == 3'(i));
    end
  end

  always_comb begin
    src_d     = src_in;
    mask_d    = we_mask ? mask_in : mask_q;
    // A new edge beats a same-cycle clear, both for pending and for lost.
    pending_d = (pending_q & ~clr) | rise;
    lost_d    = (lost_q & ~{N_SRC{clr_lost}}) | (rise & pending_q & ~clr);
  end

  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    vector_d    = vector_q;
    unique case (state_q)
      StIdle: begin
        if (int_en && (|req)) begin
          active_id_d = winner;
          vector_d    = VEC_BASE + PC_W'(winner) * VEC_STEP;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (int_ack) state_d = StService;
      end
      StService: begin
        if (int_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      src_q       <= '0;
      mask_q      <= '0;
      pending_q   <= '0;
      lost_q      <= '0;
      active_id_q <= 3'd0;
      vector_q    <= VEC_BASE;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      mask_q      <= mask_d;
      pending_q   <= pending_d;
      lost_q      <= lost_d;
      active_id_q <= active_id_d;
      vector_q    <= vector_d;
    end
  end

  assign irq        = (state_q == StReq);
  assign in_service = (state_q == StService);
  assign active_id  = active_id_q;
  assign vector     = vector_q;
  assign pending    = pending_q;
  assign lost       = lost_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: a table of per-cycle stimulus/expectation rows plus
// hand-written sequences for asynchronous reset, held-high lines and stray handshakes.
module tb_int_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] src_in;
  logic       int_en;
  logic       we_mask;
  logic [3:0] mask_in;
  logic       int_ack;
  logic       int_done;
  logic       clr_lost;
  logic       irq;
  logic [9:0] vector;
  logic       in_service;
  logic [2:0] active_id;
  logic [3:0] pending;
  logic [3:0] lost;

  int errors = 0;
  int checks = 0;

  int_ctrl #(
    .N_SRC   (4),
    .PC_W    (10),
    .VEC_BASE(10'h3C0),
    .VEC_STEP(10'd16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .src_in    (src_in),
    .int_en    (int_en),
    .we_mask   (we_mask),
    .mask_in   (mask_in),
    .int_ack   (int_ack),
    .int_done  (int_done),
    .clr_lost  (clr_lost),
    .irq       (irq),
    .vector    (vector),
    .in_service(in_service),
    .active_id (active_id),
    .pending   (pending),
    .lost      (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] src;
    logic       en;
    logic       we;
    logic [3:0] msk;
    logic       ack;
    logic       done;
    logic       clr;
    logic       e_irq;
    logic [9:0] e_vec;
    logic       e_svc;
    logic [2:0] e_id;
    logic [3:0] e_pend;
    logic [3:0] e_lost;
  } row_t;

  row_t tbl [27];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_irq, input logic [9:0] e_vec,
                         input logic e_svc, input logic [2:0] e_id, input logic [3:0] e_pend,
                         input logic [3:0] e_lost);
    chk({tag, ".irq"}, 32'(irq), 32'(e_irq));
    chk({tag, ".vector"}, 32'(vector), 32'(e_vec));
    chk({tag, ".in_service"}, 32'(in_service), 32'(e_svc));
    chk({tag, ".active_id"}, 32'(active_id), 32'(e_id));
    chk({tag, ".pending"}, 32'(pending), 32'(e_pend));
    chk({tag, ".lost"}, 32'(lost), 32'(e_lost));
  endtask

  task automatic idle_inputs();
    src_in   = 4'b0000;
    int_en   = 1'b1;
    we_mask  = 1'b0;
    mask_in  = 4'b0000;
    int_ack  = 1'b0;
    int_done = 1'b0;
    clr_lost = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // src,      en,   we,   msk,     ack,  done, clr | irq,  vec,      svc,  id,   pend,    lost
    // Single source, ack, then double event while in service (lost), clr_lost, done.
    tbl[0]  = '{4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3C0, 1'b0, 3'd0, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3C0, 1'b0, 3'd0, 4'b0001, 4'b0000};
    tbl[2]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h3C0, 1'b0, 3'd0, 4'b0001, 4'b0000};
    tbl[3]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h3C0, 1'b0, 3'd0, 4'b0001, 4'b0000};
    tbl[4]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3C0, 1'b1, 3'd0, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3C0, 1'b1, 3'd0, 4'b0001, 4'b0000};
    tbl[6]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3C0, 1'b1, 3'd0, 4'b0001, 4'b0000};
    tbl[7]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3C0, 1'b1, 3'd0, 4'b0001, 4'b0001};
    tbl[8]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 10'h3C0, 1'b1, 3'd0, 4'b0001, 4'b0000};
    tbl[9]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h3C0, 1'b0, 3'd0, 4'b0001, 4'b0000};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h3C0, 1'b0, 3'd0, 4'b0001, 4'b0000};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3C0, 1'b1, 3'd0, 4'b0000, 4'b0000};
    tbl[12] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h3C0, 1'b0, 3'd0, 4'b0000, 4'b0000};
    // Simultaneous id1/id3: id1 first, one idle cycle after done, then id3; grant frozen in REQ.
    tbl[13] = '{4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3C0, 1'b0, 3'd0, 4'b0000, 4'b0000};
    tbl[14] = '{4'b1010, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3C0, 1'b0, 3'd0, 4'b1010, 4'b0000};
    tbl[15] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h3D0, 1'b0, 3'd1, 4'b1010, 4'b0000};
    tbl[16] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3D0, 1'b1, 3'd1, 4'b1000, 4'b0000};
    tbl[17] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h3D0, 1'b0, 3'd1, 4'b1000, 4'b0000};
    tbl[18] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h3F0, 1'b0, 3'd3, 4'b1000, 4'b0000};
    tbl[19] = '{4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h3F0, 1'b0, 3'd3, 4'b1001, 4'b0000};
    tbl[20] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 10'h3F0, 1'b1, 3'd3, 4'b0001, 4'b0000};
    tbl[21] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h3F0, 1'b0, 3'd3, 4'b0001, 4'b0000};
    // Masked source pends; mask write enables it two cycles later (int_en=0 delays once more).
    tbl[22] = '{4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3F0, 1'b0, 3'd3, 4'b0101, 4'b0000};
    tbl[23] = '{4'b0000, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3F0, 1'b0, 3'd3, 4'b0101, 4'b0000};
    tbl[24] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3F0, 1'b0, 3'd3, 4'b0101, 4'b0000};
    tbl[25] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h3E0, 1'b0, 3'd2, 4'b0101, 4'b0000};
    tbl[26] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3E0, 1'b1, 3'd2, 4'b0001, 4'b0000};

    idle_inputs();
    reset = 1'b0;
    tick();
    chk_all("reset", 1'b0, 10'h3C0, 1'b0, 3'd0, 4'b0000, 4'b0000);
    reset = 1'b1;
    tick();
    chk_all("post_reset", 1'b0, 10'h3C0, 1'b0, 3'd0, 4'b0000, 4'b0000);

    for (int r = 0; r < 27; r++) begin
      src_in   = tbl[r].src;
      int_en   = tbl[r].en;
      we_mask  = tbl[r].we;
      mask_in  = tbl[r].msk;
      int_ack  = tbl[r].ack;
      int_done = tbl[r].done;
      clr_lost = tbl[r].clr;
      tick();
      chk_all($sformatf("row%0d", r), tbl[r].e_irq, tbl[r].e_vec, tbl[r].e_svc, tbl[r].e_id,
              tbl[r].e_pend, tbl[r].e_lost);
    end

    // Reset asserted while in SERVICE for id2: outputs return at once, without a clock edge.
    idle_inputs();
    src_in = 4'b0010;
    reset  = 1'b0;
    #1;
    chk_all("async_reset", 1'b0, 10'h3C0, 1'b0, 3'd0, 4'b0000, 4'b0000);
    tick();
    reset = 1'b1;
    // Line held high across release yields exactly one edge; mask is 0 so no irq.
    tick();
    chk_all("held_high", 1'b0, 10'h3C0, 1'b0, 3'd0, 4'b0010, 4'b0000);
    int_ack = 1'b1;
    tick();
    chk_all("stray_ack", 1'b0, 10'h3C0, 1'b0, 3'd0, 4'b0010, 4'b0000);
    int_ack = 1'b0;
    we_mask = 1'b1;
    mask_in = 4'b0010;
    tick();
    chk_all("mask_wr", 1'b0, 10'h3C0, 1'b0, 3'd0, 4'b0010, 4'b0000);
    we_mask = 1'b0;
    tick();
    chk_all("grant_id1", 1'b1, 10'h3D0, 1'b0, 3'd1, 4'b0010, 4'b0000);
    int_done = 1'b1;
    tick();
    chk_all("stray_done", 1'b1, 10'h3D0, 1'b0, 3'd1, 4'b0010, 4'b0000);
    int_done = 1'b0;
    int_ack  = 1'b1;
    tick();
    chk_all("ack_id1", 1'b0, 10'h3D0, 1'b1, 3'd1, 4'b0000, 4'b0000);
    int_ack  = 1'b0;
    int_done = 1'b1;
    tick();
    chk_all("done_id1", 1'b0, 10'h3D0, 1'b0, 3'd1, 4'b0000, 4'b0000);
    int_done = 1'b0;
    tick();
    chk_all("quiet", 1'b0, 10'h3D0, 1'b0, 3'd1, 4'b0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
